mbist_march_ctrl: RTL and testbench

Parametrised March C- memory BIST controller for single-port synchronous SRAMs. It generates addresses internally in both directions and drives the memory write/read strobes. It compares read data in-block through a latency-matched expected-data pipeline and reports pass/fail with the failing address and March element. It replaces the fixed 4-bit, w0/r0/w1/r1 controller and its external comparator and address counter in the MBIST wrapper.

---
 rtl/mbist_march_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller with internal address sequencing and in-block compare.
// Define MBIST_DIAG_EN to run to completion and count miscompares instead of stopping.
module mbist_march_ctrl #(
    parameter int            AW         = 4,
    parameter int            DW         = 8,
    parameter int            DEPTH      = 2 ** AW,
    parameter int            RD_LAT     = 1,
    parameter logic [DW-1:0] BACKGROUND = {DW{1'b0}},
    parameter int            CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [2:0]    fail_elem,
    output logic [CW-1:0] fail_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam int            LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] DLAST = LW'(RD_LAT - 1);

    state_t        state;
    logic [2:0]    elem;
    logic          wr_ph;
    logic [LW-1:0] dcnt;

    logic          sr_vld  [RD_LAT];
    logic [DW-1:0] sr_exp  [RD_LAT];
    logic [AW-1:0] sr_addr [RD_LAT];
    logic [2:0]    sr_elem [RD_LAT];

    logic [2:0]    n_elem;
    logic [AW-1:0] n_addr;
    logic          n_wr;
    logic          n_end;
    logic [DW-1:0] n_data;
    logic          miss;

    // Reads of E2/E4 and writes of E1/E3 use the inverted background
    function automatic logic [DW-1:0] op_data(input logic [2:0] e, input logic w);
        logic inv;
        inv = w ? (e == 3'd1 || e == 3'd3) : (e == 3'd2 || e == 3'd4);
        return inv ? ~BACKGROUND : BACKGROUND;
    endfunction

    always_comb begin
        n_elem = elem;
        n_addr = mem_addr;
        n_wr   = 1'b0;
        n_end  = 1'b0;
        unique case (elem)
            3'd0: begin
                if (mem_addr == LAST) begin
                    n_elem = 3'd1;
                    n_addr = '0;
                end else begin
                    n_addr = mem_addr + 1'b1;
                    n_wr   = 1'b1;
                end
            end
            3'd1, 3'd2: begin
                if (!wr_ph) begin
                    n_wr = 1'b1;
                end else if (mem_addr == LAST) begin
                    n_elem = elem + 3'd1;
                    n_addr = (elem == 3'd1) ? '0 : LAST;
                end else begin
                    n_addr = mem_addr + 1'b1;
                end
            end
            3'd3, 3'd4: begin
                if (!wr_ph) begin
                    n_wr = 1'b1;
                end else if (mem_addr == '0) begin
                    n_elem = elem + 3'd1;
                    n_addr = (elem == 3'd3) ? LAST : '0;
                end else begin
                    n_addr = mem_addr - 1'b1;
                end
            end
            3'd5: begin
                if (mem_addr == LAST) n_end = 1'b1;
                else n_addr = mem_addr + 1'b1;
            end
            default: n_end = 1'b1;
        endcase
    end

    assign n_data = op_data(n_elem, n_wr);
    assign miss   = busy && sr_vld[RD_LAT-1] && (mem_rdata != sr_exp[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            elem      <= '0;
            wr_ph     <= 1'b0;
            dcnt      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
`ifdef MBIST_DIAG_EN
            fail_count <= '0;
`endif
            for (int i = 0; i < RD_LAT; i++) begin
                sr_vld[i]  <= 1'b0;
                sr_exp[i]  <= '0;
                sr_addr[i] <= '0;
                sr_elem[i] <= '0;
            end
        end else begin
            // Expected-data pipeline follows the issued read by RD_LAT edges
            sr_vld[0]  <= mem_re;
            sr_exp[0]  <= mem_wdata;
            sr_addr[0] <= mem_addr;
            sr_elem[0] <= elem;
            for (int i = 1; i < RD_LAT; i++) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_exp[i]  <= sr_exp[i-1];
                sr_addr[i] <= sr_addr[i-1];
                sr_elem[i] <= sr_elem[i-1];
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
`ifdef MBIST_DIAG_EN
                        fail_count <= '0;
`endif
                        elem      <= 3'd0;
                        wr_ph     <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= BACKGROUND;
                        mem_we    <= 1'b1;
                        mem_re    <= 1'b0;
                    end
                end
                RUN: begin
                    if (n_end) begin
                        state  <= DRAIN;
                        dcnt   <= '0;
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                    end else begin
                        elem      <= n_elem;
                        mem_addr  <= n_addr;
                        wr_ph     <= n_wr;
                        mem_wdata <= n_data;
                        mem_we    <= n_wr;
                        mem_re    <= !n_wr;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DLAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (miss) begin
                if (!fail) begin
                    fail_addr <= sr_addr[RD_LAT-1];
                    fail_elem <= sr_elem[RD_LAT-1];
                end
                fail <= 1'b1;
`ifdef MBIST_DIAG_EN
                if (fail_count != {CW{1'b1}}) fail_count <= fail_count + 1'b1;
`else
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                mem_we <= 1'b0;
                mem_re <= 1'b0;
                for (int i = 0; i < RD_LAT; i++) sr_vld[i] <= 1'b0;
`endif
            end
        end
    end

`ifndef MBIST_DIAG_EN
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two configurations against behavioural SRAMs,
// per-cycle compare against a March C- op list built from the algorithm.
module tb_mbist_march_ctrl;

`ifdef MBIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    typedef struct {
        int         elem;
        bit         we;
        int         addr;
        logic [7:0] data;
    } op_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       fail;
        logic       we;
        logic       re;
        logic [7:0] addr;
        logic [7:0] wdata;
    } ov_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, we_a, re_a, busy_a, done_a, fail_a;
    logic [7:0] rdata_a, wdata_a, fcnt_a;
    logic [3:0] addr_a, faddr_a;
    logic [2:0] felem_a;
    logic       rst_b, start_b, we_b, re_b, busy_b, done_b, fail_b;
    logic [7:0] rdata_b, wdata_b, fcnt_b;
    logic [3:0] addr_b, faddr_b;
    logic [2:0] felem_b;

    mbist_march_ctrl #(
        .AW(4), .DW(8), .DEPTH(16), .RD_LAT(1), .BACKGROUND(8'h00), .CW(8)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .mem_rdata(rdata_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a), .mem_re(re_a),
        .busy(busy_a), .done(done_a), .fail(fail_a), .fail_addr(faddr_a),
        .fail_elem(felem_a), .fail_count(fcnt_a)
    );

    mbist_march_ctrl #(
        .AW(4), .DW(8), .DEPTH(10), .RD_LAT(3), .BACKGROUND(8'hA5), .CW(8)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .mem_rdata(rdata_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b), .mem_re(re_b),
        .busy(busy_b), .done(done_b), .fail(fail_b), .fail_addr(faddr_b),
        .fail_elem(felem_b), .fail_count(fcnt_b)
    );

    // SRAM A: 16 words, latency 1, optional bit0 stuck-at-1 at address 5
    logic [7:0] mem_a [16];
    logic       fault_a = 1'b0;
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= wdata_a;
        if (re_a) rdata_a <= mem_a[addr_a] | ((fault_a && addr_a == 4'd5) ? 8'h01 : 8'h00);
    end

    // SRAM B: 10 words, latency 3
    logic [7:0] mem_b [10];
    logic [7:0] rp_b [3];
    always @(posedge clk) begin
        if (we_b) mem_b[addr_b] <= wdata_b;
        if (re_b) rp_b[0] <= mem_b[addr_b];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign rdata_b = rp_b[2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic ov_t mk(input logic bz, input logic dn, input logic fl, input logic w,
                               input logic r, input logic [7:0] ad, input logic [7:0] wd);
        ov_t v;
        v.busy  = bz;
        v.done  = dn;
        v.fail  = fl;
        v.we    = w;
        v.re    = r;
        v.addr  = (w | r) ? ad : 8'h00;
        v.wdata = w ? wd : 8'h00;
        return v;
    endfunction

    function automatic op_t mkop(input int e, input bit w, input int a, input logic [7:0] d);
        op_t o;
        o.elem = e;
        o.we   = w;
        o.addr = a;
        o.data = d;
        return o;
    endfunction

    ov_t gen_q [$];
    ov_t q_a [$];
    ov_t q_b [$];

    // Expected output vector per cycle after the start edge, from the March C- algorithm
    task automatic gen(input int depth, input int lat, input logic [7:0] bg, input int faddr,
                       input bit diag, output int o_addr, output int o_elem,
                       output int o_cnt, output int o_end);
        op_t ops [$];
        int  f, cnt, n_ops, last, a;
        logic [7:0] rv, wv;
        bit  fl;
        gen_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < depth; k++) begin
                a  = (e == 3 || e == 4) ? depth - 1 - k : k;
                rv = (e == 2 || e == 4) ? ~bg : bg;
                wv = (e == 1 || e == 3) ? ~bg : bg;
                if (e == 0) ops.push_back(mkop(e, 1'b1, a, bg));
                else if (e == 5) ops.push_back(mkop(e, 1'b0, a, bg));
                else begin
                    ops.push_back(mkop(e, 1'b0, a, rv));
                    ops.push_back(mkop(e, 1'b1, a, wv));
                end
            end
        end
        f = -1;
        cnt = 0;
        foreach (ops[i]) begin
            if (!ops[i].we && ops[i].addr == faddr && ops[i].data[0] == 1'b0) begin
                if (f < 0) f = i;
                if (cnt < 255) cnt++;
            end
        end
        n_ops = ops.size();
        last = (f >= 0 && !diag) ? f + 1 + lat : n_ops + lat;
        for (int n = 0; n < last; n++) begin
            fl = (f >= 0) && (n >= f + 1 + lat);
            if (n < n_ops)
                gen_q.push_back(mk(1'b1, 1'b0, fl, ops[n].we, !ops[n].we,
                                   8'(ops[n].addr), ops[n].data));
            else
                gen_q.push_back(mk(1'b1, 1'b0, fl, 1'b0, 1'b0, 8'h00, 8'h00));
        end
        repeat (3) gen_q.push_back(mk(1'b0, 1'b1, f >= 0, 1'b0, 1'b0, 8'h00, 8'h00));
        o_addr = (f >= 0) ? ops[f].addr : 0;
        o_elem = (f >= 0) ? ops[f].elem : 0;
        o_cnt  = diag ? cnt : 0;
        o_end  = last;
    endtask

    always @(negedge clk) begin
        if (q_a.size() != 0) begin
            ov_t ev;
            ev = q_a.pop_front();
            chk("cycle_a", 64'(mk(busy_a, done_a, fail_a, we_a, re_a, {4'h0, addr_a}, wdata_a)),
                64'(ev));
        end
    end

    always @(negedge clk) begin
        if (q_b.size() != 0) begin
            ov_t ev;
            ev = q_b.pop_front();
            chk("cycle_b", 64'(mk(busy_b, done_b, fail_b, we_b, re_b, {4'h0, addr_b}, wdata_b)),
                64'(ev));
        end
    end

    int ea_addr, ea_elem, ea_cnt, ea_end;
    int eb_addr, eb_elem, eb_cnt, eb_end;

    task automatic launch_a(input bit fault);
        fault_a = fault;
        gen(16, 1, 8'h00, fault ? 5 : -1, DIAG, ea_addr, ea_elem, ea_cnt, ea_end);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        q_a = gen_q;
    endtask

    task automatic wait_done_a(input int base, output int e);
        e = -1;
        for (int i = base + 1; i <= base + 400; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                e = i;
                break;
            end
        end
        if (e < 0) q_a.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_done_b(output int e);
        e = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (done_b) begin
                e = i;
                break;
            end
        end
        if (e < 0) q_b.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_a();
        return {addr_a, wdata_a, we_a, re_a, busy_a, done_a, fail_a, faddr_a, felem_a, fcnt_a};
    endfunction

    initial begin
        int e;
        rst_a = 1'b0;
        rst_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", all_a(), 0);
        chk("reset_b", {addr_b, wdata_b, we_b, re_b, busy_b, done_b, fail_b,
                        faddr_b, felem_b, fcnt_b}, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // fault-free, depth 16, latency 1
        launch_a(1'b0);
        wait_done_a(0, e);
        chk("a_pass_done_edge", e, 161);
        chk("a_pass_flags", {busy_a, done_a, fail_a}, 3'b010);
        chk("a_pass_fcnt", fcnt_a, 0);
        chk("a_pass_drained", q_a.size(), 0);

        // depth 10, latency 3, background A5
        gen(10, 3, 8'hA5, -1, DIAG, eb_addr, eb_elem, eb_cnt, eb_end);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        q_b = gen_q;
        wait_done_b(e);
        chk("b_done_edge", e, 103);
        chk("b_model_end", eb_end, e);
        chk("b_flags", {busy_b, done_b, fail_b}, 3'b010);
        chk("b_drained", q_b.size(), 0);

        // bit0 stuck-at-1 at address 5
        launch_a(1'b1);
        wait_done_a(0, e);
        chk("a_fault_done_edge", e, DIAG ? 161 : 28);
        chk("a_fault_flags", {busy_a, done_a, fail_a, we_a, re_a}, 5'b01100);
        chk("a_fault_addr", faddr_a, 5);
        chk("a_fault_elem", felem_a, 1);
        chk("a_fault_count", fcnt_a, DIAG ? 3 : 0);
        chk("a_fault_model_addr", ea_addr, faddr_a);
        chk("a_fault_drained", q_a.size(), 0);

        // reset during E3, then a clean rerun
        launch_a(1'b0);
        repeat (90) @(posedge clk);
        #1;
        chk("a_in_e3_busy", busy_a, 1'b1);
        q_a.delete();
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        chk("a_midrun_reset", all_a(), 0);
        launch_a(1'b0);
        wait_done_a(0, e);
        chk("a_restart_done_edge", e, 161);
        chk("a_restart_flags", {busy_a, done_a, fail_a}, 3'b010);

        // start held, then pulsed mid-run
        fault_a = 1'b0;
        gen(16, 1, 8'h00, -1, DIAG, ea_addr, ea_elem, ea_cnt, ea_end);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        q_a = gen_q;
        chk("a_start_clears_done", {busy_a, done_a}, 2'b10);
        repeat (60) @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_done_a(101, e);
        chk("a_held_done_edge", e, 161);
        chk("a_held_idle", {busy_a, done_a, we_a, re_a}, 4'b0100);

        // next start after done begins a new run
        launch_a(1'b0);
        chk("a_next_start", {busy_a, done_a, fail_a}, 3'b100);
        wait_done_a(0, e);
        chk("a_next_done_edge", e, 161);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
